// File: rtl/move_stack.sv
// LIFO of DATA_W-bit move codes with push/pop/replace, synchronous clear and registered pop data.
// Optional sticky ovf/udf error flags are built when MOVE_STACK_ERR_EN is defined.
module move_stack #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              init,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
`ifdef MOVE_STACK_ERR_EN
  output logic              ovf,
  output logic              udf,
`endif
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       sp;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     top;
  logic              wr_en, rd_en, sp_inc, sp_dec;
  logic [AW-1:0]     wr_addr;

  assign full  = (sp == (AW+1)'(DEPTH));
  assign empty = (sp == '0);
  // Low bits of sp are 0 when full, so subtracting 1 lands on DEPTH-1.
  assign top   = sp[AW-1:0] - AW'(1);

  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    wr_addr = sp[AW-1:0];
    if (!init) begin
      if (push && pop && !empty) begin
        // Replace the top entry; legal even when full.
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = top;
      end else if (push && !full) begin
        wr_en  = 1'b1;
        sp_inc = 1'b1;
      end else if (pop && !push && !empty) begin
        rd_en  = 1'b1;
        sp_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= '0;
      data_out <= '0;
    end else if (init) begin
      sp <= '0;
    end else begin
      if (rd_en)  data_out <= mem[top];
      if (sp_inc) sp <= sp + (AW+1)'(1);
      if (sp_dec) sp <= sp - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

`ifdef MOVE_STACK_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (init) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && !pop && full)  ovf <= 1'b1;
      if (pop && !push && empty) udf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_move_stack.sv
// Self-checking bench for move_stack: directed scenarios plus randomized traffic vs a queue model.
module tb_move_stack;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst, push, pop, init;
  logic [DATA_W-1:0] data_in, data_out;
  logic              full, empty;
`ifdef MOVE_STACK_ERR_EN
  logic              ovf, udf;
  logic              m_ovf, m_udf;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;

  move_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .init(init),
    .data_in(data_in), .data_out(data_out), .full(full),
`ifdef MOVE_STACK_ERR_EN
    .ovf(ovf), .udf(udf),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  32'(data_out), 32'(m_dout));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
`ifdef MOVE_STACK_ERR_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
`endif
  endtask

  // Reference behaviour applied to the inputs sampled at one edge.
  task automatic model(input logic ps, input logic pp, input logic in, input logic [DATA_W-1:0] d);
    if (in) begin
      q.delete();
`ifdef MOVE_STACK_ERR_EN
      m_ovf = 1'b0; m_udf = 1'b0;
`endif
    end else if (ps && pp && q.size() > 0) begin
      m_dout = q[q.size()-1];
      q[q.size()-1] = d;
    end else if (ps && q.size() < DEPTH) begin
      q.push_back(d);
    end else if (pp && !ps && q.size() > 0) begin
      m_dout = q.pop_back();
    end else begin
`ifdef MOVE_STACK_ERR_EN
      if (ps && !pp) m_ovf = 1'b1;
      if (pp && !ps) m_udf = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic ps, input logic pp, input logic in, input logic [DATA_W-1:0] d,
                      input string tag, input bit do_chk = 1'b1);
    push = ps; pop = pp; init = in; data_in = d;
    @(posedge clk);
    #1;
    model(ps, pp, in, d);
    push = 1'b0; pop = 1'b0; init = 1'b0;
    if (do_chk) check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
`ifdef MOVE_STACK_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] v, last;
    int pw;
    rst = 1'b0; push = 1'b0; pop = 1'b0; init = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // LIFO order
    step(1, 0, 0, 2'b11, "lifo_push");
    step(1, 0, 0, 2'b00, "lifo_push");
    step(1, 0, 0, 2'b01, "lifo_push");
    step(1, 0, 0, 2'b10, "lifo_push");
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, "lifo_pop");
    chk("lifo_last", 32'(data_out), 32'h3);

    // Underflow
    step(0, 1, 0, '0, "underflow");
    chk("udf_dout", 32'(data_out), 32'h3);

    // Fill to capacity, then overflow push
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == DEPTH-1) ? 2'b01 : DATA_W'($urandom);
      step(1, 0, 0, v, "fill", i >= DEPTH-2);
    end
    chk("fill_full", 32'(full), 32'h1);
    step(1, 0, 0, 2'b11, "overflow");
    step(0, 1, 0, '0, "ovf_pop");
    chk("ovf_pop_val", 32'(data_out), 32'h1);
    chk("ovf_pop_notfull", 32'(full), 32'h0);
    // Replace while full
    step(1, 0, 0, 2'b10, "refill");
    step(1, 1, 0, 2'b00, "repl_full");
    step(0, 0, 1, '0, "init_big");

    // Replace
    step(1, 0, 0, 2'b01, "repl_setup");
    step(1, 0, 0, 2'b10, "repl_setup");
    step(1, 1, 0, 2'b11, "repl");
    chk("repl_dout", 32'(data_out), 32'h2);
    step(0, 1, 0, '0, "repl_pop1");
    chk("repl_pop1_val", 32'(data_out), 32'h3);
    step(0, 1, 0, '0, "repl_pop2");
    chk("repl_pop2_val", 32'(data_out), 32'h1);

    // Push+pop while empty acts as push
    step(1, 1, 0, 2'b10, "pp_empty");

    // Clear with three entries; init wins over push/pop
    step(1, 0, 0, 2'b11, "clr_setup");
    step(1, 0, 0, 2'b00, "clr_setup");
    step(1, 1, 1, 2'b01, "clear");
    chk("clear_dout", 32'(data_out), 32'h1);

    // Reset mid-operation, between edges
    step(1, 0, 0, 2'b10, "rmid_setup");
    step(1, 0, 0, 2'b11, "rmid_setup");
    step(0, 1, 0, '0, "rmid_setup");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    #1 rst = 1'b1;
    step(1, 0, 0, 2'b01, "post_rst_push");

    // Randomized traffic with phases biased toward growth or shrink
    for (int ph = 0; ph < 12; ph++) begin
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      for (int i = 0; i < 300; i++) begin
        last = DATA_W'($urandom);
        step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) >= pw - 10 && $urandom_range(0, 1) == 1),
             ($urandom_range(0, 199) == 0), last, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
